// File: rtl/count_seq_checker_if.sv
// Sample/result bundle between a counter under observation and count_seq_checker.
interface count_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic             locked;
    logic [WIDTH-1:0] expected;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;

    modport master (
        output en, a,
        input  locked, expected, err_pulse, err_cnt, wrap_cnt
    );

    modport slave (
        input  en, a,
        output locked, expected, err_pulse, err_cnt, wrap_cnt
    );
endinterface

// File: rtl/count_seq_checker.sv
// Increment-sequence checker: locks on a +1 counter stream, counts errors/wraps.
// Optional macro RESYNC_ON_ZERO_EN: a==0 mismatch while locked is a source reset.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8
) (
    input logic               clk,
    input logic               rst,
    count_seq_checker_if.slave bus
);
    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);

    state_t           state, state_n;
    logic [3:0]       good, good_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic [WIDTH-1:0] expected, expected_n;
    logic             locked, locked_n;
    logic             pulse, pulse_n;
    logic [CNT_W-1:0] err_cnt, err_n;
    logic [CNT_W-1:0] wrap_cnt, wrap_n;
    logic             step_ok;
    logic [3:0]       good_inc;

    assign step_ok  = (bus.a == prev + ONE_W);
    assign good_inc = good + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNSYNC;
            good     <= '0;
            prev     <= '0;
            expected <= '0;
            locked   <= 1'b0;
            pulse    <= 1'b0;
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else begin
            state    <= state_n;
            good     <= good_n;
            prev     <= prev_n;
            expected <= expected_n;
            locked   <= locked_n;
            pulse    <= pulse_n;
            err_cnt  <= err_n;
            wrap_cnt <= wrap_n;
        end
    end

    always_comb begin
        state_n    = state;
        good_n     = good;
        prev_n     = prev;
        expected_n = expected;
        locked_n   = locked;
        pulse_n    = 1'b0;
        err_n      = err_cnt;
        wrap_n     = wrap_cnt;
        if (bus.en) begin
            prev_n     = bus.a;
            expected_n = bus.a + ONE_W;
            unique case (state)
                UNSYNC: begin
                    good_n  = '0;
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (step_ok) begin
                        good_n = good_inc;
                        if (good_inc >= LOCK_V) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    if (step_ok) begin
                        // a ok step landing on zero can only come from all-ones
                        if (bus.a == '0 && wrap_cnt != '1)
                            wrap_n = wrap_cnt + ONE_C;
`ifdef RESYNC_ON_ZERO_EN
                    end else if (bus.a == '0) begin
                        state_n = LOCKED;
`endif
                    end else begin
                        pulse_n  = 1'b1;
                        locked_n = 1'b0;
                        good_n   = '0;
                        state_n  = ACQUIRE;
                        if (err_cnt != '1)
                            err_n = err_cnt + ONE_C;
                    end
                end
                default: begin
                    state_n  = UNSYNC;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.locked    = locked;
    assign bus.expected  = expected;
    assign bus.err_pulse = pulse;
    assign bus.err_cnt   = err_cnt;
    assign bus.wrap_cnt  = wrap_cnt;
endmodule
